// File: rtl/uart_tx_module.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to build the parity stage; PARITY_ODD then selects odd parity.
module uart_tx_module #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] state
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LastStop = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_module: illegal parameter value");
    end

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            bit_done;

`ifdef UART_TX_PARITY_EN
    localparam logic ParityInit = 1'(PARITY_ODD);
    logic parity_q, parity_d;
`endif

    assign bit_done = (cnt_q == CntMax);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        // Baud counter free-runs in every non-idle state and wraps on each bit boundary.
        if (state_q != StIdle) begin
            cnt_d = bit_done ? '0 : cnt_q + CntW'(1);
        end

        case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    state_d = StStart;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ ParityInit;
`endif
                end
            end
            StStart: begin
                if (bit_done) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = StParity;
                        tx_d      = parity_q;
`else
                        state_d   = StStop;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        // shift_q[1] becomes shift_d[0]: the next bit on the line
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (bit_done) begin
                    if (bit_idx_q == LastStop) begin
                        state_d   = StIdle;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                cnt_d     = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
            end
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign state    = state_q;

endmodule
